// File: rtl/ahb_sram_ctrl_if.sv
// AHB-Lite bus bundle between a master/interconnect and the SRAM controller slave.
interface ahb_sram_ctrl_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      output HREADYOUT, HRESP, HRDATA
   );

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      input  HREADYOUT, HRESP, HRDATA
   );
endinterface

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite to synchronous SRAM bridge: zero-wait reads and writes, a single
// wait state when a read address follows a write, and a two-cycle ERROR
// response for unsupported transfer sizes.
module ahb_sram_ctrl #(
   parameter int AW = 15
) (
   input  logic           HCLK,
   input  logic           HRESET,
   ahb_sram_ctrl_if.slave bus,
   input  logic [31:0]    SRAMRDATA,
   output logic [3:0]     SRAMWEN,
   output logic [31:0]    SRAMWDATA,
   output logic           SRAMCS,
   output logic [AW-1:0]  SRAMADDR
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WR,
      ST_WR2,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t        state;
   state_t        next_state;
   logic [AW-1:0] dp_addr;
   logic [3:0]    dp_mask;

   logic          req;
   logic          acc;
   logic          size_ok;
   logic          rd_acc;
   logic          wr_acc;
   logic          err_acc;
   logic          collision;
   logic [AW-1:0] haddr_word;
   logic [3:0]    hmask;
   logic          ready;
   logic          resp;
   logic [31:0]   rdata;
   logic          unused_bits;

   assign req        = bus.HSEL & bus.HTRANS[1];
   assign acc        = req & bus.HREADY;
   assign size_ok    = (bus.HSIZE <= 3'd2);
   assign rd_acc     = acc & size_ok & ~bus.HWRITE;
   assign wr_acc     = acc & size_ok & bus.HWRITE;
   assign err_acc    = acc & ~size_ok;
   assign haddr_word = bus.HADDR[AW+1:2];
   assign collision  = (state == ST_WR) & req & ~bus.HWRITE;

   // Address bits above the SRAM and the SEQ/NONSEQ distinction carry no meaning here
   assign unused_bits = ^{bus.HADDR[31:AW+2], bus.HTRANS[0]};

   // Byte-lane enables for the size and alignment of the current address phase
   always_comb begin
      hmask = 4'b0000;
      case (bus.HSIZE)
         3'd0:    hmask = 4'b0001 << bus.HADDR[1:0];
         3'd1:    hmask = bus.HADDR[1] ? 4'b1100 : 4'b0011;
         3'd2:    hmask = 4'b1111;
         default: hmask = 4'b0000;
      endcase
   end

   // Data-phase FSM: bus response for the current state and choice of the next one
   always_comb begin
      next_state = ST_IDLE;
      ready      = 1'b1;
      resp       = 1'b0;
      rdata      = 32'h0;
      case (state)
         ST_RD:   rdata = SRAMRDATA;
         ST_WR:   ready = ~collision;
         ST_ERR1: begin
            ready = 1'b0;
            resp  = 1'b1;
         end
         ST_ERR2: resp = 1'b1;
         default: ;
      endcase
      if (ready) begin
         if (rd_acc)
            next_state = ST_RD;
         else if (wr_acc)
            next_state = ST_WR;
         else if (err_acc)
            next_state = ST_ERR1;
         else
            next_state = ST_IDLE;
      end else if (state == ST_ERR1) begin
         next_state = ST_ERR2;
      end else begin
         next_state = ST_WR2;
      end
   end

   // SRAM port: a pending write owns the port, otherwise an accepted read uses it;
   // reset blocks any access immediately, including a write already in progress
   always_comb begin
      SRAMCS   = 1'b0;
      SRAMWEN  = 4'b0000;
      SRAMADDR = haddr_word;
      if (!HRESET) begin
         if (state == ST_WR) begin
            SRAMCS   = 1'b1;
            SRAMWEN  = dp_mask;
            SRAMADDR = dp_addr;
         end else if (rd_acc) begin
            SRAMCS   = 1'b1;
         end
      end
   end

   assign SRAMWDATA     = bus.HWDATA;
   assign bus.HREADYOUT = ready;
   assign bus.HRESP     = resp;
   assign bus.HRDATA    = rdata;

   // State register
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET)
         state <= ST_IDLE;
      else
         state <= next_state;
   end

   // Capture the write address and lanes so the write lands during its data phase
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         dp_addr <= '0;
         dp_mask <= 4'b0000;
      end else if (wr_acc) begin
         dp_addr <= haddr_word;
         dp_mask <= hmask;
      end
   end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Bench for ahb_sram_ctrl: a pipelined AHB driver, a behavioural SRAM and a
// transaction-level memory model that predicts every bus and SRAM response.
module tb_ahb_sram_ctrl;
   localparam int AW = 15;

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic        write;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
   } op_t;

   logic          HCLK = 1'b0;
   logic          HRESET;
   logic [31:0]   SRAMRDATA;
   logic [3:0]    SRAMWEN;
   logic [31:0]   SRAMWDATA;
   logic          SRAMCS;
   logic [AW-1:0] SRAMADDR;

   int            n_cmp = 0;
   int            n_bad = 0;
   op_t           ops[$];
   int            last_waits;
   logic [31:0]   last_rdata;
   logic [31:0]   sram [int];
   logic [31:0]   ref_mem [int];

   ahb_sram_ctrl_if bus();

   ahb_sram_ctrl #(.AW(AW)) dut (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .bus       (bus),
      .SRAMRDATA (SRAMRDATA),
      .SRAMWEN   (SRAMWEN),
      .SRAMWDATA (SRAMWDATA),
      .SRAMCS    (SRAMCS),
      .SRAMADDR  (SRAMADDR)
   );

   assign bus.HREADY = bus.HREADYOUT;

   always #5 HCLK = ~HCLK;

   // Synchronous SRAM: one-cycle read latency, per-lane writes
   always @(posedge HCLK) begin : sram_model
      logic [31:0] merged;
      if (SRAMCS) begin
         merged = sram.exists(int'(SRAMADDR)) ? sram[int'(SRAMADDR)] : 32'h0;
         if (SRAMWEN == 4'b0000) begin
            SRAMRDATA <= merged;
         end else begin
            for (int b = 0; b < 4; b++)
               if (SRAMWEN[b]) merged[8*b +: 8] = SRAMWDATA[8*b +: 8];
            sram[int'(SRAMADDR)] = merged;
         end
      end
   end

   function automatic logic [3:0] lane_mask(logic [31:0] a, logic [2:0] s);
      int nbytes;
      int lo;
      nbytes = 1 << s;
      lo = int'(a[1:0]) & ~(nbytes - 1);
      return 4'(((1 << nbytes) - 1) << lo);
   endfunction

   function automatic logic [31:0] ref_read(logic [AW-1:0] w);
      return ref_mem.exists(int'(w)) ? ref_mem[int'(w)] : 32'h0;
   endfunction

   function automatic void ref_write(logic [31:0] a, logic [2:0] s, logic [31:0] d);
      logic [31:0] v;
      logic [3:0]  m;
      v = ref_read(a[AW+1:2]);
      m = lane_mask(a, s);
      for (int b = 0; b < 4; b++)
         if (m[b]) v[8*b +: 8] = d[8*b +: 8];
      ref_mem[int'(a[AW+1:2])] = v;
   endfunction

   function automatic op_t mk_idle();
      op_t o;
      o.sel = 1'b0; o.trans = 2'b00; o.write = 1'b0;
      o.addr = 32'h0; o.size = 3'd0; o.wdata = 32'h0;
      return o;
   endfunction

   function automatic op_t mk_wr(logic [31:0] a, logic [2:0] s, logic [31:0] d);
      op_t o;
      o.sel = 1'b1; o.trans = 2'b10; o.write = 1'b1;
      o.addr = a; o.size = s; o.wdata = d;
      return o;
   endfunction

   function automatic op_t mk_rd(logic [31:0] a, logic [2:0] s);
      op_t o;
      o.sel = 1'b1; o.trans = 2'b10; o.write = 1'b0;
      o.addr = a; o.size = s; o.wdata = 32'h0;
      return o;
   endfunction

   function automatic bit is_xfer(op_t o);
      return o.sel && o.trans[1];
   endfunction

   task automatic drive_idle();
      bus.HSEL   = 1'b0;
      bus.HTRANS = 2'b00;
      bus.HWRITE = 1'b0;
      bus.HADDR  = 32'h0;
      bus.HSIZE  = 3'd0;
      bus.HWDATA = 32'h0;
   endtask

   // Runs the ops queue through a pipelined AHB master; starts and ends 1 time unit after a rising edge
   task automatic run_ops();
      op_t           pres;
      op_t           dp;
      bit            dp_valid;
      bit            dp_first;
      bit            wr_first;
      bit            pres_rd;
      int            i;
      int            cycles;
      int            limit;
      logic          exp_ready;
      logic          exp_cs;
      logic [3:0]    exp_wen;
      logic [AW-1:0] exp_addr;
      logic [31:0]   exp_rdata;
      dp_valid = 0; dp_first = 0; i = 0; cycles = 0; last_waits = 0;
      dp = mk_idle();
      limit = 3 * ops.size() + 20;
      while ((i < ops.size() || dp_valid) && cycles < limit) begin
         pres = (i < ops.size()) ? ops[i] : mk_idle();
         bus.HSEL   = pres.sel;
         bus.HTRANS = pres.trans;
         bus.HWRITE = pres.write;
         bus.HADDR  = pres.addr;
         bus.HSIZE  = pres.size;
         bus.HWDATA = (dp_valid && dp.write) ? dp.wdata : $urandom();
         wr_first  = dp_valid && dp.write && dp_first;
         pres_rd   = is_xfer(pres) && !pres.write;
         exp_ready = !(wr_first && pres_rd);
         exp_cs    = wr_first || (pres_rd && exp_ready);
         exp_wen   = wr_first ? lane_mask(dp.addr, dp.size) : 4'b0000;
         exp_addr  = wr_first ? dp.addr[AW+1:2] : pres.addr[AW+1:2];
         exp_rdata = (dp_valid && !dp.write) ? ref_read(dp.addr[AW+1:2]) : 32'h0;
         @(negedge HCLK);
         n_cmp++;
         if (bus.HREADYOUT !== exp_ready) begin
            n_bad++;
            $display("[TB] FAIL hreadyout cycle %0d: got %b expected %b", cycles, bus.HREADYOUT, exp_ready);
         end
         n_cmp++;
         if (bus.HRESP !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL hresp cycle %0d: got %b expected 0", cycles, bus.HRESP);
         end
         n_cmp++;
         if (SRAMCS !== exp_cs) begin
            n_bad++;
            $display("[TB] FAIL sramcs cycle %0d: got %b expected %b", cycles, SRAMCS, exp_cs);
         end
         n_cmp++;
         if (SRAMWEN !== exp_wen) begin
            n_bad++;
            $display("[TB] FAIL sramwen cycle %0d: got %b expected %b", cycles, SRAMWEN, exp_wen);
         end
         if (exp_cs) begin
            n_cmp++;
            if (SRAMADDR !== exp_addr) begin
               n_bad++;
               $display("[TB] FAIL sramaddr cycle %0d: got %h expected %h", cycles, SRAMADDR, exp_addr);
            end
         end
         if (wr_first) begin
            n_cmp++;
            if (SRAMWDATA !== dp.wdata) begin
               n_bad++;
               $display("[TB] FAIL sramwdata cycle %0d: got %h expected %h", cycles, SRAMWDATA, dp.wdata);
            end
            ref_write(dp.addr, dp.size, dp.wdata);
         end
         n_cmp++;
         if (bus.HRDATA !== exp_rdata) begin
            n_bad++;
            $display("[TB] FAIL hrdata cycle %0d: got %h expected %h", cycles, bus.HRDATA, exp_rdata);
         end
         if (dp_valid && !dp.write) last_rdata = bus.HRDATA;
         if (bus.HREADYOUT === 1'b1) begin
            dp_valid = is_xfer(pres);
            dp = pres;
            dp_first = 1;
            if (i < ops.size()) i++;
         end else begin
            dp_first = 0;
            last_waits++;
         end
         @(posedge HCLK);
         #1;
         cycles++;
      end
      if (cycles >= limit) begin
         n_cmp++;
         n_bad++;
         $display("[TB] FAIL run_ops timeout: got %0d cycles expected fewer than %0d", cycles, limit);
      end
      drive_idle();
   endtask

   task automatic test_reset();
      HRESET = 1'b1;
      for (int c = 0; c < 8; c++) begin
         bus.HSEL   = 1'($urandom_range(0, 1));
         bus.HTRANS = 2'($urandom_range(0, 3));
         bus.HWRITE = 1'($urandom_range(0, 1));
         bus.HADDR  = $urandom();
         bus.HSIZE  = 3'($urandom_range(0, 7));
         bus.HWDATA = $urandom();
         @(negedge HCLK);
         n_cmp++;
         if (bus.HREADYOUT !== 1'b1) begin n_bad++; $display("[TB] FAIL reset hreadyout: got %b expected 1", bus.HREADYOUT); end
         n_cmp++;
         if (bus.HRESP !== 1'b0) begin n_bad++; $display("[TB] FAIL reset hresp: got %b expected 0", bus.HRESP); end
         n_cmp++;
         if (bus.HRDATA !== 32'h0) begin n_bad++; $display("[TB] FAIL reset hrdata: got %h expected 0", bus.HRDATA); end
         n_cmp++;
         if (SRAMCS !== 1'b0) begin n_bad++; $display("[TB] FAIL reset sramcs: got %b expected 0", SRAMCS); end
         n_cmp++;
         if (SRAMWEN !== 4'b0000) begin n_bad++; $display("[TB] FAIL reset sramwen: got %b expected 0", SRAMWEN); end
         @(posedge HCLK);
         #1;
      end
      drive_idle();
      HRESET = 1'b0;
   endtask

   task automatic test_word_rw();
      ops.delete();
      ops.push_back(mk_wr(32'h10, 3'd2, 32'hDEADBEEF));
      ops.push_back(mk_idle());
      ops.push_back(mk_rd(32'h10, 3'd2));
      run_ops();
      n_cmp++;
      if (last_rdata !== 32'hDEADBEEF) begin n_bad++; $display("[TB] FAIL word_rw data: got %h expected deadbeef", last_rdata); end
      n_cmp++;
      if (last_waits !== 0) begin n_bad++; $display("[TB] FAIL word_rw waits: got %0d expected 0", last_waits); end
   endtask

   task automatic test_sub_word();
      ops.delete();
      ops.push_back(mk_wr(32'h13, 3'd0, 32'hAB000000));
      ops.push_back(mk_wr(32'h12, 3'd1, 32'h12340000));
      ops.push_back(mk_idle());
      ops.push_back(mk_rd(32'h10, 3'd2));
      run_ops();
      n_cmp++;
      if (last_rdata !== 32'h1234BEEF) begin n_bad++; $display("[TB] FAIL sub_word data: got %h expected 1234beef", last_rdata); end
   endtask

   task automatic test_collision();
      logic [31:0] d;
      d = $urandom();
      ops.delete();
      ops.push_back(mk_wr(32'h20, 3'd2, d));
      ops.push_back(mk_rd(32'h20, 3'd2));
      run_ops();
      n_cmp++;
      if (last_waits !== 1) begin n_bad++; $display("[TB] FAIL collision waits: got %0d expected 1", last_waits); end
      n_cmp++;
      if (last_rdata !== d) begin n_bad++; $display("[TB] FAIL collision data: got %h expected %h", last_rdata, d); end
   endtask

   task automatic test_back_to_back();
      ops.delete();
      for (int k = 0; k < 4; k++) ops.push_back(mk_wr(32'h40 + 32'(4 * k), 3'd2, $urandom()));
      for (int k = 0; k < 4; k++) ops.push_back(mk_rd(32'h40 + 32'(4 * k), 3'd2));
      run_ops();
      n_cmp++;
      if (last_waits !== 1) begin n_bad++; $display("[TB] FAIL back_to_back waits: got %0d expected 1", last_waits); end
   endtask

   task automatic test_error();
      for (int k = 0; k < 2; k++) begin
         bus.HSEL   = 1'b1;
         bus.HTRANS = 2'b10;
         bus.HWRITE = (k == 1);
         bus.HSIZE  = 3'($urandom_range(3, 7));
         bus.HADDR  = $urandom();
         bus.HWDATA = $urandom();
         @(negedge HCLK);
         n_cmp++;
         if (SRAMCS !== 1'b0) begin n_bad++; $display("[TB] FAIL error addr sramcs: got %b expected 0", SRAMCS); end
         @(posedge HCLK);
         #1;
         bus.HTRANS = 2'b00;
         @(negedge HCLK);
         n_cmp++;
         if (bus.HRESP !== 1'b1) begin n_bad++; $display("[TB] FAIL err1 hresp: got %b expected 1", bus.HRESP); end
         n_cmp++;
         if (bus.HREADYOUT !== 1'b0) begin n_bad++; $display("[TB] FAIL err1 hreadyout: got %b expected 0", bus.HREADYOUT); end
         n_cmp++;
         if (SRAMCS !== 1'b0) begin n_bad++; $display("[TB] FAIL err1 sramcs: got %b expected 0", SRAMCS); end
         @(posedge HCLK);
         #1;
         @(negedge HCLK);
         n_cmp++;
         if (bus.HRESP !== 1'b1) begin n_bad++; $display("[TB] FAIL err2 hresp: got %b expected 1", bus.HRESP); end
         n_cmp++;
         if (bus.HREADYOUT !== 1'b1) begin n_bad++; $display("[TB] FAIL err2 hreadyout: got %b expected 1", bus.HREADYOUT); end
         n_cmp++;
         if (SRAMCS !== 1'b0) begin n_bad++; $display("[TB] FAIL err2 sramcs: got %b expected 0", SRAMCS); end
         @(posedge HCLK);
         #1;
         @(negedge HCLK);
         n_cmp++;
         if (bus.HRESP !== 1'b0) begin n_bad++; $display("[TB] FAIL post-error hresp: got %b expected 0", bus.HRESP); end
         @(posedge HCLK);
         #1;
      end
      drive_idle();
      ops.delete();
      ops.push_back(mk_rd(32'h10, 3'd2));
      run_ops();
   endtask

   task automatic test_reset_during_write();
      logic [31:0] v;
      v = $urandom();
      ops.delete();
      ops.push_back(mk_wr(32'h30, 3'd2, v));
      run_ops();
      bus.HSEL   = 1'b1;
      bus.HTRANS = 2'b10;
      bus.HWRITE = 1'b1;
      bus.HSIZE  = 3'd2;
      bus.HADDR  = 32'h30;
      @(posedge HCLK);
      #1;
      drive_idle();
      bus.HWDATA = ~v;
      #1;
      n_cmp++;
      if (SRAMCS !== 1'b1) begin n_bad++; $display("[TB] FAIL pre-reset write sramcs: got %b expected 1", SRAMCS); end
      HRESET = 1'b1;
      #1;
      n_cmp++;
      if (SRAMCS !== 1'b0) begin n_bad++; $display("[TB] FAIL reset-in-write sramcs: got %b expected 0", SRAMCS); end
      n_cmp++;
      if (SRAMWEN !== 4'b0000) begin n_bad++; $display("[TB] FAIL reset-in-write sramwen: got %b expected 0", SRAMWEN); end
      n_cmp++;
      if (bus.HREADYOUT !== 1'b1) begin n_bad++; $display("[TB] FAIL reset-in-write hreadyout: got %b expected 1", bus.HREADYOUT); end
      @(posedge HCLK);
      #1;
      HRESET = 1'b0;
      ops.delete();
      ops.push_back(mk_rd(32'h30, 3'd2));
      run_ops();
      n_cmp++;
      if (last_rdata !== v) begin n_bad++; $display("[TB] FAIL reset-in-write readback: got %h expected %h", last_rdata, v); end
      n_cmp++;
      if (last_waits !== 0) begin n_bad++; $display("[TB] FAIL post-reset waits: got %0d expected 0", last_waits); end
   endtask

   task automatic test_random();
      op_t           o;
      int            kind;
      int            exp_waits;
      logic [31:0]   a;
      logic [2:0]    sz;
      logic [AW-1:0] w;
      ops.delete();
      exp_waits = 0;
      for (int n = 0; n < 300; n++) begin
         kind = $urandom_range(0, 9);
         sz = 3'($urandom_range(0, 2));
         if ($urandom_range(0, 3) == 0)
            w = {AW{1'b1}} - AW'($urandom_range(0, 3));
         else
            w = AW'($urandom_range(0, 7));
         a = $urandom();
         a[AW+1:2] = w;
         a[1:0] = 2'($urandom_range(0, 3)) & ~2'((1 << sz) - 1);
         if (kind < 4) begin
            o = mk_wr(a, sz, $urandom());
            o.trans = 2'($urandom_range(2, 3));
         end else if (kind < 8) begin
            o = mk_rd(a, sz);
            o.trans = 2'($urandom_range(2, 3));
         end else begin
            o = mk_idle();
            o.sel   = (kind == 8);
            o.trans = (kind == 8) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
            o.write = 1'($urandom_range(0, 1));
            o.addr  = a;
            o.size  = sz;
         end
         ops.push_back(o);
      end
      for (int n = 1; n < ops.size(); n++)
         if (is_xfer(ops[n-1]) && ops[n-1].write && is_xfer(ops[n]) && !ops[n].write) exp_waits++;
      run_ops();
      n_cmp++;
      if (last_waits !== exp_waits) begin n_bad++; $display("[TB] FAIL random waits: got %0d expected %0d", last_waits, exp_waits); end
   endtask

   initial begin
      HRESET = 1'b1;
      drive_idle();
      @(posedge HCLK);
      #1;
      test_reset();
      test_word_rw();
      test_sub_word();
      test_collision();
      test_back_to_back();
      test_error();
      test_reset_during_write();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
